// File: rtl/rc_meter_pkg.sv
// Shared types and default sizing for the RC charge-time meter.
package rc_meter_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int DIS_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISCHARGE,
    ST_CHARGE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/rc_meter.sv
// RC charge-time meter: force-discharge the node, then count clk cycles until
// the synchronized comparator reports the node crossed threshold.
module rc_meter
  import rc_meter_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DIS_CYCLES = DIS_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic             comp_in,
  output logic             charge_out,
  output logic             dis_out,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             valid,
  output logic             timeout
);

  localparam int                 DIS_W    = (DIS_CYCLES > 1) ? $clog2(DIS_CYCLES) : 1;
  localparam logic [DIS_W-1:0]   DIS_LAST = DIS_W'(DIS_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIS_W-1:0] r_dis_cnt;
  logic [CNT_W-1:0] r_result;
  logic             r_timeout;
  logic             w_comp_s;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (comp_in),
    .q   (w_comp_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dis_cnt <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
    end else if (!ena && (r_state != ST_IDLE)) begin
      // Abort: leave result/timeout untouched so the last good measurement survives.
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && ena) begin
            r_state   <= ST_DISCHARGE;
            r_dis_cnt <= '0;
          end
        end
        ST_DISCHARGE: begin
          if (r_dis_cnt == DIS_LAST) begin
            r_state <= ST_CHARGE;
            r_cnt   <= '0;
          end else begin
            r_dis_cnt <= r_dis_cnt + 1'b1;
          end
        end
        ST_CHARGE: begin
          // A threshold crossing wins over saturation on the same cycle.
          if (w_comp_s) begin
            r_result  <= r_cnt;
            r_timeout <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_cnt == CNT_MAX) begin
            r_result  <= r_cnt;
            r_timeout <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign charge_out = (r_state == ST_CHARGE);
  assign dis_out    = (r_state == ST_DISCHARGE) || (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);
  assign valid      = (r_state == ST_DONE);
  assign result     = r_result;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_rc_meter.sv
// Directed bench for rc_meter with an 8-bit counter and 4 discharge cycles.
module tb_rc_meter;

  localparam int CNT_W      = 8;
  localparam int DIS_CYCLES = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ena;
  logic             start;
  logic             comp_in;
  logic             charge_out;
  logic             dis_out;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic             valid;
  logic             timeout;

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  int vbase;
  int ncyc;

  rc_meter #(.CNT_W(CNT_W), .DIS_CYCLES(DIS_CYCLES)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .start      (start),
    .comp_in    (comp_in),
    .charge_out (charge_out),
    .dis_out    (dis_out),
    .busy       (busy),
    .result     (result),
    .valid      (valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (valid) vcnt <= vcnt + 1;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Step until valid is seen; returns the number of steps taken, or -1 if the bound expires.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!valid && n < max) begin
      step(1);
      n++;
    end
    if (!valid) n = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_chg"},    32'(charge_out), 0);
    chk({tag, "_dis"},    32'(dis_out), 0);
    chk({tag, "_valid"},  32'(valid), 0);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; start = 1'b0; comp_in = 1'b0;
    step(2);
    chk_idle_outs("rst");
    chk("rst_result",  32'(result), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Normal measurement: comp_in rises in CHARGE cycle 10 -> result 12.
    rst = 1'b0; ena = 1'b1;
    step(1);
    pulse_start();
    chk("m1_dis",  32'(dis_out), 1);
    chk("m1_busy", 32'(busy), 1);
    chk("m1_chg0", 32'(charge_out), 0);
    step(3);
    chk("m1_dis_last", 32'(dis_out), 1);
    step(1);
    chk("m1_chg",     32'(charge_out), 1);
    chk("m1_dis_off", 32'(dis_out), 0);
    step(10);
    comp_in = 1'b1;
    step(2);
    chk("m1_novalid", 32'(valid), 0);
    step(1);
    chk("m1_valid",   32'(valid), 1);
    chk("m1_result",  32'(result), 12);
    chk("m1_timeout", 32'(timeout), 0);
    chk("m1_done_dis", 32'(dis_out), 1);
    chk("m1_done_chg", 32'(charge_out), 0);
    chk("m1_done_busy", 32'(busy), 1);
    step(1);
    chk_idle_outs("m1_after");
    chk("m1_hold", 32'(result), 12);

    // comp_in held high throughout -> result 0 after 4 discharge + 1 charge cycle.
    vbase = vcnt;
    pulse_start();
    chk("m2_hold_during", 32'(result), 12);
    wait_valid(40, ncyc);
    chk("m2_latency", 32'(ncyc), 5);
    chk("m2_result",  32'(result), 0);
    chk("m2_timeout", 32'(timeout), 0);
    step(5);
    chk("m2_vcount", 32'(vcnt - vbase), 1);

    // comp_in held low -> saturates at 255 with timeout.
    comp_in = 1'b0;
    vbase = vcnt;
    pulse_start();
    wait_valid(400, ncyc);
    chk("m3_latency", 32'(ncyc), 260);
    chk("m3_result",  32'(result), 255);
    chk("m3_timeout", 32'(timeout), 1);
    step(5);
    chk("m3_vcount", 32'(vcnt - vbase), 1);
    chk("m3_hold_to", 32'(timeout), 1);

    // Second start during CHARGE is ignored; comp_in rises in CHARGE cycle 6 -> 8.
    vbase = vcnt;
    pulse_start();
    step(4);
    chk("m4_chg", 32'(charge_out), 1);
    step(3);
    pulse_start();
    step(2);
    comp_in = 1'b1;
    wait_valid(20, ncyc);
    chk("m4_latency", 32'(ncyc), 3);
    chk("m4_result",  32'(result), 8);
    chk("m4_timeout", 32'(timeout), 0);
    step(6);
    chk("m4_vcount", 32'(vcnt - vbase), 1);
    chk_idle_outs("m4_idle");

    // ena dropped in CHARGE -> immediate abort, previous result kept.
    comp_in = 1'b0;
    step(2);
    vbase = vcnt;
    pulse_start();
    step(4 + 5);
    chk("m5_chg", 32'(charge_out), 1);
    ena = 1'b0;
    step(1);
    chk_idle_outs("m5_abort");
    chk("m5_result",  32'(result), 8);
    chk("m5_timeout", 32'(timeout), 0);
    step(5);
    chk("m5_vcount", 32'(vcnt - vbase), 0);
    ena = 1'b1;
    step(1);

    // rst in DISCHARGE (with start held) -> reset values, then a normal run.
    vbase = vcnt;
    pulse_start();
    step(2);
    chk("m6_dis", 32'(dis_out), 1);
    rst = 1'b1; start = 1'b1;
    step(1);
    chk_idle_outs("m6_rst");
    chk("m6_result",  32'(result), 0);
    chk("m6_timeout", 32'(timeout), 0);
    rst = 1'b0; start = 1'b0;
    step(2);
    chk("m6_vcount", 32'(vcnt - vbase), 0);
    pulse_start();
    step(4);
    chk("m6_chg", 32'(charge_out), 1);
    comp_in = 1'b1;
    wait_valid(20, ncyc);
    chk("m6_latency", 32'(ncyc), 3);
    chk("m6_result2", 32'(result), 2);
    chk("m6_timeout2", 32'(timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
